// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one downstream APB completer segment between NUM_PORTS requesters.
// Request and response paths are fully registered; a per-transfer watchdog aborts hung completers.
module apb_arbiter #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                          pclk,
    input  logic                                          rst,
    // Upstream requester-side ports (arbiter acts as completer)
    input  logic [NUM_PORTS-1:0]                          up_psel_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]          up_paddr_i,
    input  logic [NUM_PORTS-1:0]                          up_pwrite_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]          up_pwdata_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]        up_pstrb_i,
    input  logic [NUM_PORTS-1:0][2:0]                     up_pprot_i,
    output logic [NUM_PORTS-1:0]                          up_pready_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]          up_prdata_o,
    output logic [NUM_PORTS-1:0]                          up_pslverr_o,
    // Downstream shared completer segment (arbiter acts as requester)
    output logic                                          ds_psel_o,
    output logic                                          ds_penable_o,
    output logic                                          ds_pwrite_o,
    output logic [ADDR_WIDTH-1:0]                         ds_paddr_o,
    output logic [DATA_WIDTH-1:0]                         ds_pwdata_o,
    output logic [DATA_WIDTH/8-1:0]                       ds_pstrb_o,
    output logic [2:0]                                    ds_pprot_o,
    input  logic                                          ds_pready_i,
    input  logic [DATA_WIDTH-1:0]                         ds_prdata_i,
    input  logic                                          ds_pslverr_i,
    // Status
    output logic [$clog2(NUM_PORTS)-1:0]                  active_port,
    output logic                                          busy,
    output logic [15:0]                                   timeout_count
);

    localparam int unsigned PW  = $clog2(NUM_PORTS);
    localparam int unsigned WdW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WdW-1:0] WdLast = WdW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StComplete} state_e;

    state_e                                  state_q;
    logic [PW-1:0]                           rr_q;
    logic [PW-1:0]                           active_q;
    logic                                    busy_q;
    logic                                    drop_q;
    logic [WdW-1:0]                          wd_q;
    logic [15:0]                             tcnt_q;
    logic                                    ds_psel_q;
    logic                                    ds_penable_q;
    logic                                    ds_pwrite_q;
    logic [ADDR_WIDTH-1:0]                   ds_paddr_q;
    logic [DATA_WIDTH-1:0]                   ds_pwdata_q;
    logic [DATA_WIDTH/8-1:0]                 ds_pstrb_q;
    logic [2:0]                              ds_pprot_q;
    logic [NUM_PORTS-1:0]                    up_pready_q;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    up_prdata_q;
    logic [NUM_PORTS-1:0]                    up_pslverr_q;

    logic                                    req_found;
    logic [PW-1:0]                           req_idx;
    logic [PW:0]                             sum;
    logic [PW-1:0]                           cand;
    logic                                    deliver;

    // First requesting index at or after the RR pointer, wrapping modulo NUM_PORTS.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sum = {1'b0, rr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(NUM_PORTS)) begin
                sum = sum - (PW+1)'(NUM_PORTS);
            end
            cand = sum[PW-1:0];
            if (!req_found && up_psel_i[cand]) begin
                req_found = 1'b1;
                req_idx   = cand;
            end
        end
    end

    // A requester that dropped psel mid-transfer gets no response.
    assign deliver = !drop_q && up_psel_i[active_q];

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_q         <= '0;
            active_q     <= '0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
            wd_q         <= '0;
            tcnt_q       <= '0;
            ds_psel_q    <= 1'b0;
            ds_penable_q <= 1'b0;
            ds_pwrite_q  <= 1'b0;
            ds_paddr_q   <= '0;
            ds_pwdata_q  <= '0;
            ds_pstrb_q   <= '0;
            ds_pprot_q   <= '0;
            up_pready_q  <= '0;
            up_prdata_q  <= '0;
            up_pslverr_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_found) begin
                        ds_paddr_q  <= up_paddr_i[req_idx];
                        ds_pwrite_q <= up_pwrite_i[req_idx];
                        ds_pwdata_q <= up_pwdata_i[req_idx];
                        ds_pstrb_q  <= up_pstrb_i[req_idx];
                        ds_pprot_q  <= up_pprot_i[req_idx];
                        ds_psel_q   <= 1'b1;
                        active_q    <= req_idx;
                        busy_q      <= 1'b1;
                        drop_q      <= 1'b0;
                        state_q     <= StSetup;
                    end
                end
                StSetup: begin
                    ds_penable_q <= 1'b1;
                    wd_q         <= '0;
                    if (!up_psel_i[active_q]) drop_q <= 1'b1;
                    state_q      <= StAccess;
                end
                StAccess: begin
                    if (!up_psel_i[active_q]) drop_q <= 1'b1;
                    if (ds_pready_i) begin
                        ds_psel_q    <= 1'b0;
                        ds_penable_q <= 1'b0;
                        state_q      <= StComplete;
                        if (deliver) begin
                            up_pready_q[active_q]  <= 1'b1;
                            up_prdata_q[active_q]  <= ds_prdata_i;
                            up_pslverr_q[active_q] <= ds_pslverr_i;
                        end
                    end else if (TIMEOUT_CYCLES != 0 && wd_q == WdLast) begin
                        ds_psel_q    <= 1'b0;
                        ds_penable_q <= 1'b0;
                        state_q      <= StComplete;
                        if (tcnt_q != 16'hffff) tcnt_q <= tcnt_q + 16'd1;
                        if (deliver) begin
                            up_pready_q[active_q]  <= 1'b1;
                            up_prdata_q[active_q]  <= '0;
                            up_pslverr_q[active_q] <= 1'b1;
                        end
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                StComplete: begin
                    up_pready_q  <= '0;
                    up_prdata_q  <= '0;
                    up_pslverr_q <= '0;
                    rr_q         <= (active_q == PW'(NUM_PORTS - 1)) ? '0 : active_q + 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign up_pready_o   = up_pready_q;
    assign up_prdata_o   = up_prdata_q;
    assign up_pslverr_o  = up_pslverr_q;
    assign ds_psel_o     = ds_psel_q;
    assign ds_penable_o  = ds_penable_q;
    assign ds_pwrite_o   = ds_pwrite_q;
    assign ds_paddr_o    = ds_paddr_q;
    assign ds_pwdata_o   = ds_pwdata_q;
    assign ds_pstrb_o    = ds_pstrb_q;
    assign ds_pprot_o    = ds_pprot_q;
    assign active_port   = active_q;
    assign busy          = busy_q;
    assign timeout_count = tcnt_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed requester traffic, scoreboard of expected upstream responses,
// behavioural downstream completer with configurable wait states / hang.
module tb_apb_arbiter;

    logic                 pclk = 1'b0;
    logic                 rst  = 1'b1;
    logic [1:0]           up_psel   = '0;
    logic [1:0][15:0]     up_paddr  = '0;
    logic [1:0]           up_pwrite = '0;
    logic [1:0][31:0]     up_pwdata = '0;
    logic [1:0][3:0]      up_pstrb  = '0;
    logic [1:0][2:0]      up_pprot  = '0;
    logic [1:0]           up_pready;
    logic [1:0][31:0]     up_prdata;
    logic [1:0]           up_pslverr;
    logic                 ds_psel, ds_penable, ds_pwrite, ds_pready, ds_pslverr;
    logic [15:0]          ds_paddr;
    logic [31:0]          ds_pwdata, ds_prdata;
    logic [3:0]           ds_pstrb;
    logic [2:0]           ds_pprot;
    logic [0:0]           active_port;
    logic                 busy;
    logic [15:0]          timeout_count;

    always #5 pclk = ~pclk;

    apb_arbiter #(
        .NUM_PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(8)
    ) dut (
        .pclk(pclk), .rst(rst),
        .up_psel_i(up_psel), .up_paddr_i(up_paddr), .up_pwrite_i(up_pwrite),
        .up_pwdata_i(up_pwdata), .up_pstrb_i(up_pstrb), .up_pprot_i(up_pprot),
        .up_pready_o(up_pready), .up_prdata_o(up_prdata), .up_pslverr_o(up_pslverr),
        .ds_psel_o(ds_psel), .ds_penable_o(ds_penable), .ds_pwrite_o(ds_pwrite),
        .ds_paddr_o(ds_paddr), .ds_pwdata_o(ds_pwdata), .ds_pstrb_o(ds_pstrb),
        .ds_pprot_o(ds_pprot), .ds_pready_i(ds_pready), .ds_prdata_i(ds_prdata),
        .ds_pslverr_i(ds_pslverr),
        .active_port(active_port), .busy(busy), .timeout_count(timeout_count)
    );

    // Downstream completer: reads return the address unless a fixed value is configured.
    int          cfg_waits = 0;
    bit          cfg_hang  = 0;
    bit          cfg_fixed = 0;
    bit          cfg_err   = 0;
    logic [31:0] cfg_rdata = '0;
    int          wcnt      = 0;

    always @(posedge pclk) begin
        if (ds_psel && ds_penable && !ds_pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end
    assign ds_pready  = ds_psel && ds_penable && !cfg_hang && (wcnt == cfg_waits);
    assign ds_prdata  = ds_pwrite ? 32'h0 : (cfg_fixed ? cfg_rdata : {16'h0, ds_paddr});
    assign ds_pslverr = cfg_err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic push(input int p, input logic [31:0] d, input logic e);
        exp_t x;
        x.port = p; x.data = d; x.err = e;
        sb.push_back(x);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every upstream pready must match the next expected response.
    always @(negedge pclk) begin
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                if (up_pready[p]) begin
                    n_chk++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL resp_unexpected: port %0d pready with data %h err %b, none expected",
                                 p, up_prdata[p], up_pslverr[p]);
                    end else begin
                        mon_e = sb.pop_front();
                        if (mon_e.port != p || up_prdata[p] !== mon_e.data ||
                            up_pslverr[p] !== mon_e.err) begin
                            n_fail++;
                            $display("FAIL resp: got port %0d data %h err %b, expected port %0d data %h err %b",
                                     p, up_prdata[p], up_pslverr[p], mon_e.port, mon_e.data, mon_e.err);
                        end
                    end
                end
            end
        end
    end

    // Requester transfer; caller is positioned just after a rising edge.
    task automatic req(input int p, input bit wr, input logic [15:0] a, input logic [31:0] d);
        int k;
        up_psel[p]   = 1'b1;
        up_pwrite[p] = wr;
        up_paddr[p]  = a;
        up_pwdata[p] = d;
        up_pstrb[p]  = wr ? 4'hF : 4'h0;
        up_pprot[p]  = 3'b000;
        for (k = 0; k < 200; k++) begin
            @(negedge pclk);
            if (up_pready[p]) break;
        end
        if (k == 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_timeout: port %0d addr %h got no pready, required within 200 cycles", p, a);
        end
        @(posedge pclk);
        #1;
        up_psel[p] = 1'b0;
    endtask

    task automatic wait_ds_pready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge pclk);
            if (ds_pready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int n;
        // Reset state
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst_psel", ds_psel, 0);
        chk("rst_penable", ds_penable, 0);
        chk("rst_paddr", ds_paddr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_active", active_port, 0);
        chk("rst_tcnt", timeout_count, 0);
        chk("rst_pready", up_pready, 0);
        @(posedge pclk);
        #1 rst = 1'b0;

        // Single write from port 0: cycle-exact latency
        push(0, 32'h0, 1'b0);
        up_psel[0] = 1'b1; up_pwrite[0] = 1'b1; up_paddr[0] = 16'h0010;
        up_pwdata[0] = 32'h0000_00A5; up_pstrb[0] = 4'hF;
        @(negedge pclk);
        chk("c0_psel", ds_psel, 0);
        @(negedge pclk);
        chk("c1_psel", ds_psel, 1);
        chk("c1_penable", ds_penable, 0);
        chk("c1_busy", busy, 1);
        chk("c1_pwrite", ds_pwrite, 1);
        @(negedge pclk);
        chk("c2_penable", ds_penable, 1);
        chk("c2_paddr", ds_paddr, 16'h0010);
        chk("c2_pwdata", ds_pwdata, 32'h0000_00A5);
        chk("c2_pstrb", ds_pstrb, 4'hF);
        @(negedge pclk);
        chk("c3_pready", up_pready[0], 1);
        @(posedge pclk);
        #1 up_psel[0] = 1'b0; up_pwrite[0] = 1'b0;
        @(negedge pclk);
        chk("c4_busy", busy, 0);
        chk("c4_pready", up_pready[0], 0);
        @(posedge pclk);
        #1;

        // Both ports reading continuously; pointer is at 1 after the write
        push(1, 32'h200, 0); push(0, 32'h100, 0); push(1, 32'h204, 0); push(0, 32'h104, 0);
        fork
            begin req(0, 0, 16'h0100, 0); req(0, 0, 16'h0104, 0); end
            begin req(1, 0, 16'h0200, 0); req(1, 0, 16'h0204, 0); end
        join
        chk("alt_active", active_port, 0);

        // Five wait states, error response
        cfg_waits = 5; cfg_fixed = 1; cfg_rdata = 32'hDEAD_BEEF; cfg_err = 1;
        push(0, 32'hDEAD_BEEF, 1);
        fork
            req(0, 0, 16'h0020, 0);
            begin
                n = 0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge pclk);
                    if (ds_pready) break;
                    if (ds_penable) n++;
                end
                chk("ws_wait_cycles", n, 5);
                @(negedge pclk);
                chk("ws_pready_lat", up_pready[0], 1);
            end
        join
        cfg_waits = 0; cfg_fixed = 0; cfg_err = 0;

        // Watchdog abort after 8 ACCESS cycles
        cfg_hang = 1;
        chk("wd_tcnt_before", timeout_count, 0);
        push(1, 32'h0, 1);
        fork
            req(1, 0, 16'h0030, 0);
            begin
                n = 0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge pclk);
                    if (ds_psel && ds_penable) n++;
                    else if (n > 0) break;
                end
                chk("wd_access_cycles", n, 8);
            end
        join
        chk("wd_tcnt_after", timeout_count, 1);
        cfg_hang = 0;
        push(0, 32'h300, 0);
        req(0, 0, 16'h0300, 0);
        chk("wd_tcnt_hold", timeout_count, 1);

        // Reset during ACCESS
        cfg_hang = 1;
        up_psel[0] = 1'b1; up_pwrite[0] = 1'b0; up_paddr[0] = 16'h0040; up_pstrb[0] = 4'h0;
        repeat (3) @(negedge pclk);
        chk("mid_penable", ds_penable, 1);
        @(posedge pclk);
        #1 rst = 1'b1; up_psel[0] = 1'b0;
        @(posedge pclk);
        #1 rst = 1'b0;
        @(negedge pclk);
        chk("mid_rst_psel", ds_psel, 0);
        chk("mid_rst_penable", ds_penable, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_active", active_port, 0);
        chk("mid_rst_paddr", ds_paddr, 0);
        chk("mid_rst_pready", up_pready, 0);
        cfg_hang = 0;
        @(posedge pclk);
        #1;
        // Pointer back at 0: port 0 wins the tie, then port 1
        push(0, 32'h400, 0); push(1, 32'h500, 0);
        fork
            req(0, 0, 16'h0400, 0);
            req(1, 0, 16'h0500, 0);
        join

        // Port 1 drops psel mid-ACCESS
        cfg_waits = 3;
        up_psel[1] = 1'b1; up_pwrite[1] = 1'b0; up_paddr[1] = 16'h0050; up_pstrb[1] = 4'h0;
        repeat (3) @(negedge pclk);
        chk("drop_active", active_port, 1);
        @(posedge pclk);
        #1 up_psel[1] = 1'b0;
        push(0, 32'h600, 0); push(1, 32'h700, 0);
        fork
            req(0, 0, 16'h0600, 0);
            begin
                wait_ds_pready(ok);
                chk("drop_ds_done", ok, 1);
                @(posedge pclk);
                #1 req(1, 0, 16'h0700, 0);
            end
        join
        cfg_waits = 0;

        repeat (5) @(negedge pclk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Shares one downstream APB completer segment between NUM_PORTS upstream APB requesters, e.g. the FMC bridge and an internal DMA/debug master contending for the flash/LED peripheral segment.
- Uses round-robin arbitration and fully registered request and response paths.
- A per-transfer watchdog aborts hung completers with PSLVERR, so a dead peripheral cannot lock out the FMC host.

Parameters:
- NUM_PORTS, 2: number of upstream requesters (2..8).
- DATA_WIDTH, 32: APB data width; PSTRB width is DATA_WIDTH/8.
- ADDR_WIDTH, 16: APB address width, identical on all ports.
- TIMEOUT_CYCLES, 255: maximum ACCESS-state cycles waiting for downstream PREADY; 0 disables the watchdog.

Ports:
- pclk  input  1  APB clock for all ports.
- rst  input  1  reset. Decided: one clock; reset is synchronous and active-high.
- upstream  APB completer modport  array [NUM_PORTS-1:0]  requester-side APB ports (DATA_WIDTH, ADDR_WIDTH, USER_WIDTH=0).
- downstream  APB requester modport  1  shared completer segment.
- active_port  output  $clog2(NUM_PORTS)  index of the current or last granted port.
- busy  output  1  high in any state except IDLE.
- timeout_count  output  16  count of watchdog aborts; saturates at 0xffff.

Behaviour:
- State machine: IDLE -> SETUP -> ACCESS -> COMPLETE -> IDLE.

Reset values (applied at the first pclk edge with rst high, regardless of state):
- downstream.psel/penable/pwrite = 0; paddr/pwdata/pstrb/pprot = 0.
- All upstream pready/pslverr = 0; all upstream prdata = 0.
- RR pointer = 0; active_port = 0; busy = 0; timeout_count = 0; watchdog counter = 0; state = IDLE.

Arbitration and transfer sequence:
- IDLE: requests are the ports with upstream[i].psel = 1. The winner is the first requesting index at or after the RR pointer, wrapping modulo NUM_PORTS.
- On a win, register the winner's paddr, pwrite, pwdata, pstrb and pprot; set active_port = winner; go to SETUP. With no request, stay in IDLE.
- SETUP (1 cycle): downstream psel = 1, penable = 0; go to ACCESS.
- ACCESS: downstream psel = 1, penable = 1, watchdog counting.
  - On downstream.pready: register prdata and pslverr, drop downstream psel/penable the next cycle, go to COMPLETE.
  - If TIMEOUT_CYCLES != 0 and the watchdog reaches TIMEOUT_CYCLES without pready: drop downstream psel/penable, set response prdata = 0 and pslverr = 1, increment timeout_count (saturating), go to COMPLETE.
- COMPLETE (1 cycle): upstream[active_port].pready = 1 with the registered prdata/pslverr. The RR pointer becomes (active_port+1) mod NUM_PORTS. Go to IDLE.

Non-granted ports:
- pready = 0 at all times; they stall in ACCESS per APB rules.
- prdata = 0 and pslverr = 0.

Latency:
- Upstream psel seen in IDLE at cycle 0 gives downstream SETUP at cycle 1 and ACCESS at cycle 2.
- With zero-wait completer pready at cycle 2, upstream pready is at cycle 3.
- Minimum 4 cycles per transfer including the return to IDLE.
- A requester re-asserting psel in the cycle after its pready is arbitrated in that IDLE cycle.

Fairness:
- With all ports requesting continuously, grants rotate 0,1,...,NUM_PORTS-1,0.
- No port waits more than NUM_PORTS-1 transfers.

Protocol-violation handling:
- If the granted requester drops psel before completion, the downstream transfer still completes normally.
- The response is discarded: no pready is issued to that port. The RR pointer still advances.

Other rules:
- Downstream signals are stable from SETUP through the end of ACCESS; they are never changed mid-transfer.
- Reset mid-transfer: downstream psel drops at the reset edge, and no upstream pready is issued for the aborted transfer.

Test Plan:
- Single requester, port 0 write 0x0000_00A5 to addr 0x0010, completer zero-wait -> downstream psel at cycle 1, penable at cycle 2 with matching addr/data/strb; upstream[0].pready = 1 at cycle 3 only; busy low at cycle 4.
- Ports 0 and 1 both requesting reads continuously, completer returns addr as data -> grants alternate 0,1,0,1; each port receives its own prdata; other port's pready stays 0.
- Completer inserts 5 wait states on a read returning 0xDEAD_BEEF with pslverr = 1 -> upstream pready exactly one cycle after downstream pready, prdata = 0xDEAD_BEEF, pslverr = 1.
- TIMEOUT_CYCLES = 8, completer never asserts pready -> downstream psel drops after 8 ACCESS cycles; upstream pready = 1 with pslverr = 1, prdata = 0; timeout_count 0 -> 1; next request proceeds normally.
- rst asserted for 1 cycle during ACCESS -> all outputs at reset values next cycle, RR pointer = 0; a fresh transfer from port 1 then completes correctly.
- Port 1 drops psel mid-ACCESS -> downstream completes; port 1 receives no pready; next grant goes to port 0 if it is requesting.
